// File: rtl/mnist_infer_ctrl.sv
// MNIST inference sequencer: pixel capture, shared serial MAC over a weight ROM, arg-max tracking.
// Latency: result_valid pulses NUM_OUT*(NUM_IN+1)+2 cycles after the last pixel; pix_ready is high only while loading.
module mnist_infer_ctrl #(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 10,
  parameter int W_W     = 4,
  parameter int ACC_W   = 12,
  parameter int AW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           pix_valid,
  input  logic           pix_data,
  output logic           pix_ready,
  output logic [AW-1:0]  w_addr,
  input  logic [W_W-1:0] w_data,
  output logic           busy,
  output logic           result_valid,
  output logic [3:0]     digit
);

  localparam int IW = $clog2(NUM_IN);
  localparam int NW = $clog2(NUM_OUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_CMP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic [NW-1:0]      n_q, n_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [NUM_IN-1:0]  pbuf_q, pbuf_d;
  logic [3:0]         digit_q, digit_d;
  logic               pend_q, pend_d;
  logic               rv_q;
  logic [ACC_W-1:0]   w_ext;

  assign w_ext        = {{(ACC_W-W_W){w_data[W_W-1]}}, w_data};
  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q;
  assign digit        = digit_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    n_d        = n_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    pbuf_d     = pbuf_q;
    digit_d    = digit_q;
    pend_d     = 1'b0;
    pix_ready  = 1'b0;
    w_addr     = '0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          i_d     = '0;
          n_d     = '0;
          acc_d   = '0;
        end
      end
      S_LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          pbuf_d[i_q] = pix_data;
          if (i_q == IW'(NUM_IN-1)) begin
            state_d = S_MAC;
            i_d     = '0;
            n_d     = '0;
            acc_d   = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        w_addr = AW'(n_q) * AW'(NUM_IN) + AW'(i_q);
        acc_d  = acc_q + (pbuf_q[i_q] ? w_ext : '0);
        if (i_q == IW'(NUM_IN-1)) begin
          state_d = S_CMP;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_CMP: begin
        // Strict compare so equal scores keep the earliest class.
        if (n_q == '0 || $signed(acc_q) > $signed(best_q)) begin
          best_d     = acc_q;
          best_idx_d = 4'(n_q);
        end
        if (n_q == NW'(NUM_OUT-1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MAC;
          n_d     = n_q + 1'b1;
          i_d     = '0;
          acc_d   = '0;
        end
      end
      S_DONE: begin
        digit_d = best_idx_q;
        pend_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      i_d        = '0;
      n_d        = '0;
      acc_d      = '0;
      pend_d     = 1'b0;
      digit_d    = digit_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      pbuf_d     = pbuf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      pbuf_q     <= '0;
      digit_q    <= '0;
      pend_q     <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      pbuf_q     <= pbuf_d;
      digit_q    <= digit_d;
      pend_q     <= pend_d;
      rv_q       <= pend_q;
    end
  end

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Directed bench for mnist_infer_ctrl: table of images/ROM patterns plus reset and abort sequences.
module tb_mnist_infer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, pix_valid, pix_data;
  logic       pix_ready, busy, result_valid;
  logic [7:0] w_addr;
  logic [3:0] w_data;
  logic [3:0] digit;

  logic [3:0] rom [0:255];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] img;
    int          rom_kind;
    logic        gaps;
    logic        noisy;
    logic [3:0]  exp_digit;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  always_comb w_data = rom[w_addr];

  mnist_infer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .result_valid(result_valid), .digit(digit)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind 0: zero; 1: w=1 for n==7; 2: -1 except w(3,0)=0; 3: -1 except rows 5,6 = +7;
  // 4: w=-1 on i==n; 5: w=5 on i==n
  task automatic set_rom(input int kind);
    for (int a = 0; a < 256; a++) rom[a] = 4'd0;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 16; i++) begin
        case (kind)
          1: rom[n*16+i] = (n == 7) ? 4'd1 : 4'd0;
          2: rom[n*16+i] = (n == 3 && i == 0) ? 4'd0 : 4'hF;
          3: rom[n*16+i] = (n == 5 || n == 6) ? 4'd7 : 4'hF;
          4: rom[n*16+i] = (i == n) ? 4'hF : 4'd0;
          5: rom[n*16+i] = (i == n) ? 4'd5 : 4'd0;
          default: rom[n*16+i] = 4'd0;
        endcase
      end
    end
  endtask

  task automatic load_image(input logic [15:0] img, input logic gaps);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int p = 0; p < 16; p++) begin
      pix_valid = 1'b1;
      pix_data  = img[p];
      @(posedge clk); #1;
      if (gaps && p != 15) begin
        pix_valid = 1'b0;
        pix_data  = 1'b1;
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b0;
    pix_data  = 1'b0;
  endtask

  task automatic wait_result(input logic noisy, output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (noisy && k <= 40) begin
        pix_valid = 1'b1;
        pix_data  = 1'b1;
        start     = k[0];
      end else begin
        pix_valid = 1'b0;
        pix_data  = 1'b0;
        start     = 1'b0;
      end
      @(posedge clk); #1;
      if (noisy && k == 5) check("pix_ready_in_mac", pix_ready, 0);
      if (result_valid) begin
        lat = k;
        break;
      end
    end
    pix_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int lat;
    set_rom(v.rom_kind);
    load_image(v.img, v.gaps);
    wait_result(v.noisy, lat);
    check($sformatf("latency[%0d]", idx), lat, 172);
    check($sformatf("digit[%0d]", idx), digit, v.exp_digit);
    @(posedge clk); #1;
    check($sformatf("rv_width[%0d]", idx), result_valid, 0);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{img: 16'h0000, rom_kind: 2, gaps: 1'b0, noisy: 1'b0, exp_digit: 4'd0};
    vecs[1] = '{img: 16'hFFFF, rom_kind: 1, gaps: 1'b0, noisy: 1'b0, exp_digit: 4'd7};
    vecs[2] = '{img: 16'hFFFF, rom_kind: 2, gaps: 1'b0, noisy: 1'b0, exp_digit: 4'd3};
    vecs[3] = '{img: 16'hFFFF, rom_kind: 3, gaps: 1'b0, noisy: 1'b0, exp_digit: 4'd5};
    vecs[4] = '{img: 16'hA5A5, rom_kind: 4, gaps: 1'b1, noisy: 1'b1, exp_digit: 4'd1};
    vecs[5] = '{img: 16'h0200, rom_kind: 5, gaps: 1'b0, noisy: 1'b0, exp_digit: 4'd9};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
    set_rom(0);
    #3;
    check("rst_busy", busy, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_digit", digit, 0);
    check("rst_w_addr", w_addr, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    for (int v = 0; v < 6; v++) run_case(vecs[v], v);

    // Asynchronous reset in the middle of loading.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_pix_ready", pix_ready, 1);
    pix_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pix_ready", pix_ready, 0);
    check("arst_digit", digit, 0);
    check("arst_result_valid", result_valid, 0);
    pix_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle_busy", busy, 0);
    check("arst_idle_pix_ready", pix_ready, 0);

    // Abort during compute keeps the previous result.
    run_case(vecs[1], 6);
    load_image(16'hFFFF, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mac_w_addr", w_addr, 19);
    repeat (30) @(posedge clk);
    #1;
    check("cmp_w_addr", w_addr, 0);
    check("cmp_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_digit", digit, 7);
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    check("abort_no_result", pulses, 0);
    check("abort_digit_hold", digit, 7);
    run_case(vecs[3], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mnist_infer_ctrl.md
Name: mnist_infer_ctrl

Overview:
Inference sequencer for the MNIST accelerator: captures one binarised image as a pixel stream, sequences a single shared multiply-accumulate over an external signed weight ROM for every output neuron, and tracks the arg-max. The winning class index is registered as `digit`, which drives the top-level 7-segment decoder. It sits between the pin-level pixel input logic and the display path, and owns all compute scheduling.

Parameters:
NUM_IN, 16, pixels per image (downscaled 4x4 binary image)
NUM_OUT, 10, output neurons / classes
W_W, 4, signed weight width
ACC_W, 12, signed accumulator width; must be >= W_W + clog2(NUM_IN) + 1
AW, 8, weight address width; must be >= clog2(NUM_IN*NUM_OUT)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new image; honoured only in IDLE
abort  input  1  synchronous cancel; return to IDLE, no result
pix_valid  input  1  pixel presented
pix_data  input  1  binary pixel value
pix_ready  output  1  controller accepts pixel this cycle
w_addr  output  AW  weight ROM address = n*NUM_IN + i
w_data  input  W_W  signed weight; combinational ROM, same-cycle
busy  output  1  high in every state except IDLE
result_valid  output  1  one-cycle pulse when digit updates
digit  output  4  arg-max class index, held until next result

Behaviour:
- Clocking: single clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, pix_ready=0, busy=0, result_valid=0, digit=0, w_addr=0, acc=0, best=0, best_idx=0, counters=0, pixel buffer=0. Reset mid-operation discards all work.
- State IDLE: when start=1, clear counters and go to LOAD. When start=0, remain.
- State LOAD: pix_ready=1.
  - On pix_valid & pix_ready, store pix_data into buf[cnt] and increment cnt.
  - Gaps in pix_valid stall the load with no penalty.
  - After the NUM_IN-th accepted pixel, go to MAC with n=0, i=0, acc=0.
- State MAC: pix_ready=0; w_addr=n*NUM_IN+i.
  - Each cycle: acc <= acc + (buf[i] ? sext(w_data) : 0), then i++.
  - After the i=NUM_IN-1 cycle, go to CMP.
- State CMP (1 cycle):
  - If n==0 or acc > best (signed, strict), then best<=acc and best_idx<=n.
  - Ties keep the lowest index.
  - If n==NUM_OUT-1, go to DONE; else n++, i=0, acc=0, go to MAC.
- State DONE (1 cycle): digit<=best_idx; result_valid=1 in the following cycle (registered pulse, exactly 1 cycle); go to IDLE.
- Latency: result_valid rises NUM_OUT*(NUM_IN+1)+2 cycles after the clock edge that accepts the last pixel. With defaults this is 172.
- start: ignored outside IDLE; start and abort together in IDLE means abort wins (stay IDLE).
- abort: in any non-IDLE state, next state is IDLE. acc/counters are cleared; digit and best_idx are not updated; result_valid stays 0.
- Arithmetic: two's complement; acc wraps at ACC_W bits. Sizing rule guarantees no overflow.
- w_addr: drives 0 outside MAC.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-LOAD -> immediately busy=0, pix_ready=0, digit=0, result_valid=0; after release, state IDLE.
- All-zero image, any ROM -> all acc=0, tie -> digit=0; result_valid single pulse exactly 172 cycles after last pixel accepted.
- All-ones image, ROM w(n,i)=1 if n==7 else 0 -> acc(7)=16, others 0 -> digit=7.
- Signed compare: all-ones image, ROM w=-1 everywhere except w(3,0)=0 -> acc(3)=-15, others -16 -> digit=3; w(5,*)=+7, w(6,*)=+7 -> digit=5 (tie keeps lowest).
- Handshake: pix_valid toggling 1-0-1 with pixel pattern 0xA5A5 (buf[0]=1) -> exactly 16 pixels captured; extra pix_valid ignored once busy in MAC; start pulses during MAC are ignored.
- abort after 50 MAC cycles, with previous digit=7 -> IDLE next cycle, busy=0, no result_valid, digit stays 7; new start + image then completes normally.
